// File: rtl/lisp_eval_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lisp_defs (package)
// Description : Shared definitions for the Lisp evaluator: word tags,
//               primitive opcodes, error codes and word field helpers.
//               Helpers work on 64-bit containers with a runtime payload
//               width so any WORD_W up to 64 can use them.
// Revision    : 1.0 - initial release
// ============================================================================
package lisp_defs;

    localparam logic [15:0] LISP_NIL = 16'h0000;

    typedef enum logic [1:0] {
        TAG_NIL  = 2'd0,
        TAG_INT  = 2'd1,
        TAG_CONS = 2'd2,
        TAG_PRIM = 2'd3
    } lisp_tag_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } prim_op_e;

    localparam logic [15:0] C_FETCH_ERROR = 16'hAAAA;
    localparam logic [15:0] C_TYPE_ERROR  = 16'hBBBB;
    localparam logic [15:0] C_STACK_OVF   = 16'hCCCC;

    // Tag field: everything above the payload.
    function automatic logic [63:0] word_tag(input logic [63:0] w, input int p);
        return w >> p;
    endfunction

    // Payload field: the low p bits.
    function automatic logic [63:0] word_payload(input logic [63:0] w, input int p);
        return w & ((64'd1 << p) - 64'd1);
    endfunction

    // INT-tagged word carrying the low p bits of payload.
    function automatic logic [63:0] make_int(input logic [63:0] payload, input int p);
        return (64'(TAG_INT) << p) | (payload & ((64'd1 << p) - 64'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lisp_eval_core_if.sv
`default_nettype none
// ============================================================================
// Module      : lisp_eval_core_if
// Description : Cell-memory read bus. master = evaluator, slave = memory.
//               mem_req/mem_addr stay stable until the cycle mem_ready=1,
//               when mem_data is captured.
// Revision    : 1.0 - initial release
// ============================================================================
interface lisp_eval_core_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_data;

    modport master (output mem_req, output mem_addr, input mem_ready, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_data);
endinterface
`default_nettype wire

// File: rtl/lisp_eval_core_cont_stack.sv
`default_nettype none
// ============================================================================
// Module      : lisp_cont_stack
// Description : LIFO of continuation frames. frame_out always shows the top
//               entry; push when full and pop when empty are ignored.
//               clear empties the stack synchronously.
// Ports       : clk, rst (async active-low), clear, push, pop, frame_in,
//               frame_out, full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module lisp_cont_stack #(
    parameter int DEPTH   = 8,
    parameter int FRAME_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               clear,
    input  wire logic               push,
    input  wire logic               pop,
    input  wire logic [FRAME_W-1:0] frame_in,
    output logic      [FRAME_W-1:0] frame_out,
    output logic                    full,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   r_sp;
    // Sized to the pointer range so the pointer indexes it without truncation.
    logic [FRAME_W-1:0] r_mem [0:(1 << PTR_W) - 1];

    assign full      = (r_sp == PTR_W'(DEPTH));
    assign empty     = (r_sp == '0);
    assign frame_out = r_mem[r_sp - PTR_W'(1)];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp <= '0;
        end else if (clear) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + PTR_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            r_mem[r_sp] <= frame_in;
        end
    end
endmodule
`default_nettype wire

// File: rtl/lisp_eval_core.sv
`default_nettype none
// ============================================================================
// Module      : lisp_eval_core
// Description : Evaluates an atom or nested primitive application
//               (ADD/SUB/AND/OR) by walking cons cells over the memory bus.
//               Enclosing applications are saved on a continuation stack.
// Ports       : clk, rst (async active-low), start, expr_in,
//               mem (lisp_eval_core_if.master), val, busy, done, err,
//               err_code
// Options     : LISP_MEM_TIMEOUT_EN - abort a memory read that waits
//               TIMEOUT_CYCLES cycles, error code 16'hAAAA.
// Revision    : 1.0 - initial release
// ============================================================================
module lisp_eval_core
    import lisp_defs::*;
#(
    parameter int WORD_W         = 16,
    parameter int TAG_W          = 2,
    parameter int ADDR_W         = 16,
    parameter int STACK_DEPTH    = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [WORD_W-1:0] expr_in,
    lisp_eval_core_if.master       mem,
    output logic      [WORD_W-1:0] val,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic      [15:0]       err_code
);
    localparam int P       = WORD_W - TAG_W;
    localparam int FRAME_W = 2 + P + 1 + ADDR_W;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0, ST_DISPATCH = 4'd1, ST_FETCH_OP = 4'd2, ST_FETCH_ARG = 4'd3,
        ST_FETCH_NEXT = 4'd4, ST_COMBINE = 4'd5, ST_RETURN = 4'd6, ST_HALT = 4'd7,
        ST_ERROR = 4'd8
    } state_e;

    state_e            r_state;
    prim_op_e          r_op;
    logic [P-1:0]      r_acc, r_arg;
    logic              r_acc_empty;
    logic [ADDR_W-1:0] r_ptr, r_mem_addr;
    logic [WORD_W-1:0] r_expr, r_val;
    logic              r_mem_req, r_busy, r_done, r_err;
    logic [15:0]       r_err_code;

    logic [TAG_W-1:0]   w_mem_tag, w_expr_tag;
    logic [P-1:0]       w_mem_pay, w_combined, w_result, w_frame_acc;
    logic [ADDR_W-1:0]  w_mem_ptr, w_expr_ptr, w_fetch_addr, w_frame_ptr;
    logic               w_mem_prim_ok, w_fetch_done, w_start_ok, w_push, w_pop;
    logic               w_stack_full, w_stack_empty, w_frame_acc_empty, w_fault;
    logic [15:0]        w_fault_code;
    logic [FRAME_W-1:0] w_frame_in, w_frame_out;
    prim_op_e           w_frame_op;

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
    assign val          = r_val;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign err_code     = r_err_code;

    assign w_mem_tag     = TAG_W'(word_tag(64'(mem.mem_data), P));
    assign w_mem_pay     = P'(word_payload(64'(mem.mem_data), P));
    assign w_mem_ptr     = ADDR_W'(word_payload(64'(mem.mem_data), P));
    assign w_expr_tag    = TAG_W'(word_tag(64'(r_expr), P));
    assign w_expr_ptr    = ADDR_W'(word_payload(64'(r_expr), P));
    assign w_mem_prim_ok = (w_mem_tag == TAG_W'(TAG_PRIM)) &&
                           (word_payload(64'(mem.mem_data), P) < 64'd4);

    assign w_fetch_done = r_mem_req && mem.mem_ready;
    assign w_start_ok   = start && (r_state == ST_IDLE || r_state == ST_HALT ||
                                    r_state == ST_ERROR);
    // Cdr lives one word above the cell address held in r_ptr.
    assign w_fetch_addr = (r_state == ST_FETCH_NEXT) ? r_ptr + ADDR_W'(1) : r_ptr;
    assign w_result     = r_acc_empty ? '0 : r_acc;

    assign w_push = (r_state == ST_FETCH_ARG) && w_fetch_done &&
                    (w_mem_tag == TAG_W'(TAG_CONS)) && !w_stack_full;
    assign w_pop  = (r_state == ST_RETURN) && !w_stack_empty;

    assign w_frame_in        = {r_op, r_acc, r_acc_empty, r_ptr};
    assign w_frame_op        = prim_op_e'(w_frame_out[FRAME_W-1 -: 2]);
    assign w_frame_acc       = w_frame_out[ADDR_W+1 +: P];
    assign w_frame_acc_empty = w_frame_out[ADDR_W];
    assign w_frame_ptr       = w_frame_out[ADDR_W-1:0];

    lisp_cont_stack #(.DEPTH(STACK_DEPTH), .FRAME_W(FRAME_W)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_start_ok),
        .push      (w_push),
        .pop       (w_pop),
        .frame_in  (w_frame_in),
        .frame_out (w_frame_out),
        .full      (w_stack_full),
        .empty     (w_stack_empty)
    );

    // The first argument seeds the accumulator; later ones fold into it.
    always_comb begin
        w_combined = r_arg;
        if (!r_acc_empty) begin
            case (r_op)
                OP_ADD:  w_combined = r_acc + r_arg;
                OP_SUB:  w_combined = r_acc - r_arg;
                OP_AND:  w_combined = r_acc & r_arg;
                default: w_combined = r_acc | r_arg;
            endcase
        end
    end

`ifdef LISP_MEM_TIMEOUT_EN
    logic [31:0] r_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (!r_mem_req) begin
            r_wait <= '0;
        end else if (!mem.mem_ready) begin
            r_wait <= r_wait + 32'd1;
        end
    end
`else
    localparam int C_UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

    // All error exits in one place so the state register has one error path.
    always_comb begin
        w_fault      = 1'b0;
        w_fault_code = C_TYPE_ERROR;
        case (r_state)
            ST_DISPATCH: begin
                if (w_expr_tag != TAG_W'(TAG_NIL) && w_expr_tag != TAG_W'(TAG_INT) &&
                    w_expr_tag != TAG_W'(TAG_CONS)) begin
                    w_fault = 1'b1;
                end
            end
            ST_FETCH_OP: w_fault = w_fetch_done && !w_mem_prim_ok;
            ST_FETCH_NEXT: begin
                w_fault = w_fetch_done && (w_mem_tag != TAG_W'(TAG_NIL)) &&
                          (w_mem_tag != TAG_W'(TAG_CONS));
            end
            ST_FETCH_ARG: begin
                if (w_fetch_done) begin
                    if (w_mem_tag == TAG_W'(TAG_CONS)) begin
                        if (w_stack_full) begin
                            w_fault      = 1'b1;
                            w_fault_code = C_STACK_OVF;
                        end
                    end else if (w_mem_tag != TAG_W'(TAG_INT)) begin
                        w_fault = 1'b1;
                    end
                end
            end
            default: ;
        endcase
`ifdef LISP_MEM_TIMEOUT_EN
        if (r_mem_req && !mem.mem_ready && (r_wait + 32'd1 >= 32'(TIMEOUT_CYCLES))) begin
            w_fault      = 1'b1;
            w_fault_code = C_FETCH_ERROR;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_val       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= LISP_NIL;
            r_expr      <= '0;
            r_op        <= OP_ADD;
            r_acc       <= '0;
            r_arg       <= '0;
            r_acc_empty <= 1'b1;
            r_ptr       <= '0;
        end else if (w_start_ok) begin
            r_expr     <= expr_in;
            r_val      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= LISP_NIL;
            r_busy     <= 1'b1;
            r_state    <= ST_DISPATCH;
        end else if (w_fault) begin
            r_state    <= ST_ERROR;
            r_err      <= 1'b1;
            r_err_code <= w_fault_code;
            r_val      <= '0;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_val <= expr_in;
                ST_DISPATCH: begin
                    if (w_expr_tag == TAG_W'(TAG_CONS)) begin
                        r_ptr   <= w_expr_ptr;
                        r_state <= ST_FETCH_OP;
                    end else begin
                        r_val   <= r_expr;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_HALT;
                    end
                end
                ST_FETCH_OP, ST_FETCH_NEXT, ST_FETCH_ARG: begin
                    // Fetch states are always entered with mem_req low, which
                    // guarantees an idle bus cycle between requests.
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_fetch_addr;
                    end else if (mem.mem_ready) begin
                        r_mem_req <= 1'b0;
                        case (r_state)
                            ST_FETCH_OP: begin
                                r_op        <= prim_op_e'(w_mem_pay[1:0]);
                                r_acc       <= '0;
                                r_acc_empty <= 1'b1;
                                r_state     <= ST_FETCH_NEXT;
                            end
                            ST_FETCH_NEXT: begin
                                if (w_mem_tag == TAG_W'(TAG_NIL)) begin
                                    r_state <= ST_RETURN;
                                end else begin
                                    r_ptr   <= w_mem_ptr;
                                    r_state <= ST_FETCH_ARG;
                                end
                            end
                            default: begin
                                if (w_mem_tag == TAG_W'(TAG_INT)) begin
                                    r_arg   <= w_mem_pay;
                                    r_state <= ST_COMBINE;
                                end else begin
                                    // Nested list: frame pushed this cycle.
                                    r_ptr   <= w_mem_ptr;
                                    r_state <= ST_FETCH_OP;
                                end
                            end
                        endcase
                    end
                end
                ST_COMBINE: begin
                    r_acc       <= w_combined;
                    r_acc_empty <= 1'b0;
                    r_state     <= ST_FETCH_NEXT;
                end
                ST_RETURN: begin
                    if (w_stack_empty) begin
                        r_val   <= WORD_W'(make_int(64'(w_result), P));
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_HALT;
                    end else begin
                        r_op        <= w_frame_op;
                        r_acc       <= w_frame_acc;
                        r_acc_empty <= w_frame_acc_empty;
                        r_ptr       <= w_frame_ptr;
                        r_arg       <= w_result;
                        r_state     <= ST_COMBINE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
